dcache_responder: RTL and testbench

Responder side of the data-memory interface driven by the pipeline's MEM stage. It serves word-aligned loads and stores with byte enables from a direct-mapped, write-back, write-allocate cache. Misses are resolved over a 256-bit line interface to physical memory. It sits between the MEM stage and the memory arbiter/physical memory.

---
 rtl/dcache_pkg.sv | 14 +
 rtl/dcache_array.sv | 80 ++++++++
 rtl/dcache_responder.sv | 134 +++++++++++++
 tb/tb_dcache_responder.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared types and constants for the data cache responder
package dcache_pkg;

    localparam int LINE_BITS  = 256;
    localparam int S_OFFSET   = 5;
    localparam int LINE_BYTES = LINE_BITS / 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        FILL      = 2'd2
    } dcache_state_t;

endpackage

// File: rtl/dcache_array.sv
// rtl/dcache_array.sv - per-set valid/dirty/tag/line storage, async read, sync write
module dcache_array
    import dcache_pkg::*;
#(
    parameter int S_INDEX = 3,
    parameter int TAG_W   = 32 - S_INDEX - S_OFFSET
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [S_INDEX-1:0]    index,
    output logic                  rd_valid,
    output logic                  rd_dirty,
    output logic [TAG_W-1:0]      rd_tag,
    output logic [LINE_BITS-1:0]  rd_line,
    input  logic [LINE_BYTES-1:0] byte_we,
    input  logic [LINE_BITS-1:0]  wr_line,
    input  logic                  set_dirty,
    input  logic                  load,
    input  logic [TAG_W-1:0]      load_tag
);

    localparam int SETS = 1 << S_INDEX;

    logic [SETS-1:0]      valid_q, valid_d;
    logic [SETS-1:0]      dirty_q, dirty_d;
    logic [TAG_W-1:0]     tag_q  [SETS];
    logic [TAG_W-1:0]     tag_d  [SETS];
    logic [LINE_BITS-1:0] line_q [SETS];
    logic [LINE_BITS-1:0] line_d [SETS];

    assign rd_valid = valid_q[index];
    assign rd_dirty = dirty_q[index];
    assign rd_tag   = tag_q[index];
    assign rd_line  = line_q[index];

    // Next contents: a full-line load replaces the set, otherwise merge enabled bytes.
    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        for (int s = 0; s < SETS; s++) begin
            tag_d[s]  = tag_q[s];
            line_d[s] = line_q[s];
        end
        if (load) begin
            line_d[index]  = wr_line;
            tag_d[index]   = load_tag;
            valid_d[index] = 1'b1;
            dirty_d[index] = 1'b0;
        end else begin
            for (int b = 0; b < LINE_BYTES; b++) begin
                if (byte_we[b]) begin
                    line_d[index][8*b +: 8] = wr_line[8*b +: 8];
                end
            end
            if (set_dirty) begin
                dirty_d[index] = 1'b1;
            end
        end
    end

    // Status bits are cleared by reset; tag and data are left as they were.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    // Tag and line storage, no reset.
    always_ff @(posedge clk) begin
        for (int s = 0; s < SETS; s++) begin
            tag_q[s]  <= tag_d[s];
            line_q[s] <= line_d[s];
        end
    end

endmodule

// File: rtl/dcache_responder.sv
// rtl/dcache_responder.sv - direct-mapped write-back data cache serving the MEM stage
module dcache_responder
    import dcache_pkg::*;
#(
    parameter int S_INDEX  = 3,
    parameter int S_OFFSET = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          mem_address,
    input  logic [31:0]          mem_wdata,
    input  logic [3:0]           mem_byte_enable,
    input  logic                 data_read,
    input  logic                 data_write,
    output logic [31:0]          mem_rdata,
    output logic                 mem_resp,
    output logic [31:0]          pmem_address,
    input  logic [LINE_BITS-1:0] pmem_rdata,
    output logic [LINE_BITS-1:0] pmem_wdata,
    output logic                 pmem_read,
    output logic                 pmem_write,
    input  logic                 pmem_resp
);

    localparam int TAG_W = 32 - S_INDEX - S_OFFSET;

    dcache_state_t state_q, state_d;

    logic [TAG_W-1:0]      req_tag;
    logic [S_INDEX-1:0]    req_index;
    logic [2:0]            req_word;
    logic                  req;
    logic                  hit;
    logic                  rd_valid, rd_dirty;
    logic [TAG_W-1:0]      rd_tag;
    logic [LINE_BITS-1:0]  rd_line;
    logic [LINE_BYTES-1:0] byte_we;
    logic [LINE_BITS-1:0]  wr_line;
    logic                  set_dirty;
    logic                  load;
    logic [31:0]           sel_word;
    logic                  unused_addr_bits;

    assign req_tag          = mem_address[31:S_INDEX+S_OFFSET];
    assign req_index        = mem_address[S_INDEX+S_OFFSET-1:S_OFFSET];
    assign req_word         = mem_address[S_OFFSET-1:2];
    assign unused_addr_bits = ^mem_address[1:0];
    assign req              = data_read | data_write;
    assign hit              = rd_valid && (rd_tag == req_tag);
    assign sel_word         = rd_line[{req_word, 5'b00000} +: 32];
    // Fill data goes in whole; store data is replicated so any word lane can pick it up.
    assign wr_line          = load ? pmem_rdata : {8{mem_wdata}};

    dcache_array #(
        .S_INDEX (S_INDEX),
        .TAG_W   (TAG_W)
    ) u_array (
        .clk       (clk),
        .rst       (rst),
        .index     (req_index),
        .rd_valid  (rd_valid),
        .rd_dirty  (rd_dirty),
        .rd_tag    (rd_tag),
        .rd_line   (rd_line),
        .byte_we   (byte_we),
        .wr_line   (wr_line),
        .set_dirty (set_dirty),
        .load      (load),
        .load_tag  (req_tag)
    );

    // Controller: hits answer in IDLE; misses walk WRITEBACK (if dirty) then FILL.
    always_comb begin
        state_d      = state_q;
        mem_resp     = 1'b0;
        byte_we      = '0;
        set_dirty    = 1'b0;
        load         = 1'b0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        case (state_q)
            IDLE: begin
                if (req && hit) begin
                    mem_resp = 1'b1;
                    if (data_write) begin
                        byte_we   = {{(LINE_BYTES-4){1'b0}}, mem_byte_enable} << {req_word, 2'b00};
                        set_dirty = |mem_byte_enable;
                    end
                end else if (req) begin
                    state_d = (rd_valid && rd_dirty) ? WRITEBACK : FILL;
                end
            end
            WRITEBACK: begin
                pmem_write   = 1'b1;
                pmem_address = {rd_tag, req_index, {S_OFFSET{1'b0}}};
                pmem_wdata   = rd_line;
                if (pmem_resp) begin
                    state_d = FILL;
                end
            end
            FILL: begin
                pmem_read    = 1'b1;
                pmem_address = {req_tag, req_index, {S_OFFSET{1'b0}}};
                if (pmem_resp) begin
                    load    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Memory strobes stay Moore during reset; only the response and array writes are killed.
        if (rst) begin
            mem_resp  = 1'b0;
            byte_we   = '0;
            set_dirty = 1'b0;
            load      = 1'b0;
        end
        mem_rdata = mem_resp ? sel_word : 32'd0;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: tb/tb_dcache_responder.sv
// tb/tb_dcache_responder.sv - directed self-checking bench for dcache_responder
module tb_dcache_responder;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  mem_address;
    logic [31:0]  mem_wdata;
    logic [3:0]   mem_byte_enable;
    logic         data_read;
    logic         data_write;
    logic [31:0]  mem_rdata;
    logic         mem_resp;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_rdata;
    logic [255:0] pmem_wdata;
    logic         pmem_read;
    logic         pmem_write;
    logic         pmem_resp;

    int total_cnt = 0;
    int pass_cnt  = 0;

    always #5 clk = ~clk;

    dcache_responder dut (
        .clk             (clk),
        .rst             (rst),
        .mem_address     (mem_address),
        .mem_wdata       (mem_wdata),
        .mem_byte_enable (mem_byte_enable),
        .data_read       (data_read),
        .data_write      (data_write),
        .mem_rdata       (mem_rdata),
        .mem_resp        (mem_resp),
        .pmem_address    (pmem_address),
        .pmem_rdata      (pmem_rdata),
        .pmem_wdata      (pmem_wdata),
        .pmem_read       (pmem_read),
        .pmem_write      (pmem_write),
        .pmem_resp       (pmem_resp)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        exp_resp;
        logic        chk_data;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [12];

    logic [255:0] l40, l40_mod, l140, l240;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] mk_line(input logic [31:0] base);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[32*i +: 32] = base + 32'(i);
        return l;
    endfunction

    task automatic req_set(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [3:0] be, input logic [31:0] wd);
        data_read       = rd;
        data_write      = wr;
        mem_address     = addr;
        mem_byte_enable = be;
        mem_wdata       = wd;
    endtask

    // Acts as physical memory for one writeback or fill transaction.
    task automatic serve(input string tag, input logic is_wb, input logic [31:0] addr,
                         input logic [255:0] line, input int exp_wait);
        int n;
        n = 0;
        while (!(pmem_read || pmem_write) && n < 30) begin
            cyc();
            n++;
        end
        chk({tag, "_wait"}, 256'(n), 256'(exp_wait));
        if (n >= 30) return;
        chk({tag, "_wr"}, 256'(pmem_write), 256'(is_wb));
        chk({tag, "_rd"}, 256'(pmem_read), 256'(!is_wb));
        chk({tag, "_addr"}, 256'(pmem_address), 256'(addr));
        chk({tag, "_noresp"}, 256'(mem_resp), 256'(0));
        if (is_wb) chk({tag, "_wdata"}, pmem_wdata, line);
        repeat (2) cyc();
        chk({tag, "_held"}, 256'(is_wb ? pmem_write : pmem_read), 256'(1));
        pmem_resp = 1'b1;
        if (!is_wb) pmem_rdata = line;
        cyc();
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        chk({tag, "_drop"}, 256'(is_wb ? pmem_write : pmem_read), 256'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        l40 = mk_line(32'h4000_0000);
        l40[31:0]  = 32'hDEAD_BEEF;
        l40[95:64] = 32'hDEAD_BEEF;
        l140 = mk_line(32'h1400_0000);
        l240 = mk_line(32'h2400_0000);
        l40_mod = l40;
        l40_mod[63:32]   = 32'h1234_5678;
        l40_mod[95:64]   = 32'hDEAB_BEEF;
        l40_mod[127:96]  = 32'h4000_00EE;
        l40_mod[159:128] = 32'h4000_CAFE;
        l40_mod[255:224] = 32'hAA00_0007;

        // Back-to-back hits on the resident line at 0x40 (word2 already 0xDEABBEEF).
        vecs[0]  = '{1'b1, 1'b0, 32'h0000_0040, 4'h0, 32'h0,         1'b1, 1'b1, 32'hDEAD_BEEF};
        vecs[1]  = '{1'b1, 1'b0, 32'h0000_005C, 4'h0, 32'h0,         1'b1, 1'b1, 32'h4000_0007};
        vecs[2]  = '{1'b0, 1'b1, 32'h0000_0044, 4'hF, 32'h1234_5678, 1'b1, 1'b0, 32'h0};
        vecs[3]  = '{1'b1, 1'b0, 32'h0000_0044, 4'h0, 32'h0,         1'b1, 1'b1, 32'h1234_5678};
        vecs[4]  = '{1'b0, 1'b1, 32'h0000_0050, 4'h3, 32'h0000_CAFE, 1'b1, 1'b0, 32'h0};
        vecs[5]  = '{1'b1, 1'b0, 32'h0000_0050, 4'h0, 32'h0,         1'b1, 1'b1, 32'h4000_CAFE};
        vecs[6]  = '{1'b0, 1'b1, 32'h0000_005C, 4'h8, 32'hAA00_0000, 1'b1, 1'b0, 32'h0};
        vecs[7]  = '{1'b1, 1'b0, 32'h0000_005C, 4'h0, 32'h0,         1'b1, 1'b1, 32'hAA00_0007};
        vecs[8]  = '{1'b1, 1'b1, 32'h0000_004C, 4'h1, 32'h0000_00EE, 1'b1, 1'b0, 32'h0};
        vecs[9]  = '{1'b0, 1'b0, 32'h0000_004C, 4'h0, 32'h0,         1'b0, 1'b1, 32'h0};
        vecs[10] = '{1'b1, 1'b0, 32'h0000_004C, 4'h0, 32'h0,         1'b1, 1'b1, 32'h4000_00EE};
        vecs[11] = '{1'b1, 1'b0, 32'h0000_0043, 4'h0, 32'h0,         1'b1, 1'b1, 32'hDEAD_BEEF};

        // Reset state
        rst = 1'b1;
        pmem_resp = 1'b0;
        pmem_rdata = '0;
        req_set(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        repeat (2) cyc();
        #1;
        chk("rst_mem_resp", 256'(mem_resp), 256'(0));
        chk("rst_mem_rdata", 256'(mem_rdata), 256'(0));
        chk("rst_pmem_read", 256'(pmem_read), 256'(0));
        chk("rst_pmem_write", 256'(pmem_write), 256'(0));
        chk("rst_pmem_address", 256'(pmem_address), 256'(0));
        chk("rst_pmem_wdata", pmem_wdata, 256'(0));
        rst = 1'b0;
        cyc();

        // Clean miss on 0x40
        req_set(1'b1, 1'b0, 32'h0000_0040, 4'h0, 32'h0);
        #1;
        chk("miss_no_resp", 256'(mem_resp), 256'(0));
        chk("miss_rdata_zero", 256'(mem_rdata), 256'(0));
        serve("fill40", 1'b0, 32'h0000_0040, l40, 1);
        #1;
        chk("fill40_resp", 256'(mem_resp), 256'(1));
        chk("fill40_rdata", 256'(mem_rdata), 256'(32'hDEAD_BEEF));
        cyc();

        // Write hit with single lane, then read back
        req_set(1'b0, 1'b1, 32'h0000_0048, 4'b0100, 32'h00AB_0000);
        #1;
        chk("wr_hit_resp", 256'(mem_resp), 256'(1));
        cyc();
        req_set(1'b1, 1'b0, 32'h0000_0048, 4'h0, 32'h0);
        #1;
        chk("rd_after_wr_resp", 256'(mem_resp), 256'(1));
        chk("rd_after_wr_data", 256'(mem_rdata), 256'(32'hDEAB_BEEF));
        cyc();

        // Table of single-cycle hit vectors
        for (int i = 0; i < 12; i++) begin
            req_set(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].be, vecs[i].wdata);
            #1;
            chk($sformatf("vec%0d_resp", i), 256'(mem_resp), 256'(vecs[i].exp_resp));
            if (vecs[i].chk_data)
                chk($sformatf("vec%0d_rdata", i), 256'(mem_rdata), 256'(vecs[i].exp_rdata));
            cyc();
        end

        // Dirty conflict: writeback of modified 0x40 line, then fill of 0x140
        req_set(1'b1, 1'b0, 32'h0000_0140, 4'h0, 32'h0);
        #1;
        chk("dirty_miss_no_resp", 256'(mem_resp), 256'(0));
        serve("wb40", 1'b1, 32'h0000_0040, l40_mod, 1);
        serve("fill140", 1'b0, 32'h0000_0140, l140, 0);
        #1;
        chk("fill140_resp", 256'(mem_resp), 256'(1));
        chk("fill140_rdata", 256'(mem_rdata), 256'(32'h1400_0000));
        cyc();

        // Zero-enable store leaves the line clean and unchanged
        req_set(1'b0, 1'b1, 32'h0000_0144, 4'h0, 32'hFFFF_FFFF);
        #1;
        chk("be0_resp", 256'(mem_resp), 256'(1));
        cyc();
        req_set(1'b1, 1'b0, 32'h0000_0144, 4'h0, 32'h0);
        #1;
        chk("be0_rdata", 256'(mem_rdata), 256'(32'h1400_0001));
        cyc();
        req_set(1'b1, 1'b0, 32'h0000_0048, 4'h0, 32'h0);
        #1;
        chk("clean_miss_no_resp", 256'(mem_resp), 256'(0));
        serve("refill40", 1'b0, 32'h0000_0040, l40_mod, 1);
        #1;
        chk("refill40_resp", 256'(mem_resp), 256'(1));
        chk("refill40_rdata", 256'(mem_rdata), 256'(32'hDEAB_BEEF));
        cyc();

        // Reset during FILL with pmem_resp withheld
        req_set(1'b1, 1'b0, 32'h0000_0240, 4'h0, 32'h0);
        cyc();
        chk("rstfill_read_up", 256'(pmem_read), 256'(1));
        rst = 1'b1;
        cyc();
        chk("rstfill_read_drop", 256'(pmem_read), 256'(0));
        chk("rstfill_write_low", 256'(pmem_write), 256'(0));
        rst = 1'b0;
        #1;
        chk("rstfill_miss_again", 256'(mem_resp), 256'(0));
        serve("rerd240", 1'b0, 32'h0000_0240, l240, 1);
        #1;
        chk("rerd240_resp", 256'(mem_resp), 256'(1));
        chk("rerd240_rdata", 256'(mem_rdata), 256'(32'h2400_0000));
        cyc();

        req_set(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        #1;
        chk("final_idle_resp", 256'(mem_resp), 256'(0));
        cyc();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
